// File: rtl/ring_pkg.sv
// Shared types and constants for the ring counter checker.
package ring_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } ring_state_e;

    localparam int ERR_CNT_W = 8;
    localparam int REV_CNT_W = 16;

    localparam logic [ERR_CNT_W-1:0] ERR_SAT = 8'd255;

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary encoder with a one-hot validity flag.
module onehot_to_bin #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_is_onehot
);

    // OR-encode the set bit positions; result is only meaningful when one-hot
    always_comb begin
        o_idx = {IDX_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            o_idx = o_idx | (i_vec[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
    end

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero
    always_comb begin
        o_is_onehot = (i_vec != {WIDTH{1'b0}}) &&
                      ((i_vec & (i_vec - {{(WIDTH-1){1'b0}}, 1'b1})) == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/ring_counter_checker.sv
// Receive-side monitor for a one-hot ring counter: lock tracking, error and
// revolution counting with registered outputs.
module ring_counter_checker
    import ring_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int LOCK_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         q_in,
    input  logic                     in_valid,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     idx_valid,
    output logic                     locked,
    output logic                     err,
    output logic [ERR_CNT_W-1:0]     err_count,
    output logic                     wrap,
    output logic [REV_CNT_W-1:0]     rev_count
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int ACQ_W = $clog2(LOCK_CYCLES + 1);

    ring_state_e          r_state;
    logic [WIDTH-1:0]     r_ref;
    logic [ACQ_W-1:0]     r_acq_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_idx_valid;
    logic                 r_locked;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic                 r_wrap;
    logic [REV_CNT_W-1:0] r_rev_count;

    logic [IDX_W-1:0]     w_idx;
    logic                 w_is_onehot;
    logic [WIDTH-1:0]     w_expected;
    logic                 w_match;
    logic [ACQ_W-1:0]     w_acq_next;

    onehot_to_bin #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_decode (
        .i_vec       (q_in),
        .o_idx       (w_idx),
        .o_is_onehot (w_is_onehot)
    );

    // Expected word is the last accepted sample rotated left by one
    always_comb begin
        w_expected = {r_ref[WIDTH-2:0], r_ref[WIDTH-1]};
        w_match    = (q_in == w_expected);
        w_acq_next = r_acq_cnt + {{(ACQ_W-1){1'b0}}, 1'b1};
    end

    // Sequence-tracking FSM, counters and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HUNT;
            r_ref       <= {WIDTH{1'b0}};
            r_acq_cnt   <= {ACQ_W{1'b0}};
            r_idx       <= {IDX_W{1'b0}};
            r_idx_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= {ERR_CNT_W{1'b0}};
            r_wrap      <= 1'b0;
            r_rev_count <= {REV_CNT_W{1'b0}};
        end else if (in_valid) begin
            r_err       <= 1'b0;
            r_wrap      <= 1'b0;
            r_idx_valid <= w_is_onehot;
            if (w_is_onehot) begin
                r_idx <= w_idx;
            end
            case (r_state)
                HUNT: begin
                    if (w_is_onehot) begin
                        r_ref     <= q_in;
                        r_acq_cnt <= {ACQ_W{1'b0}};
                        r_state   <= ACQ;
                    end
                end
                ACQ: begin
                    if (w_match) begin
                        r_ref     <= q_in;
                        r_acq_cnt <= w_acq_next;
                        if (w_acq_next == ACQ_W'(LOCK_CYCLES)) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                        end
                    end else if (w_is_onehot) begin
                        r_ref     <= q_in;
                        r_acq_cnt <= {ACQ_W{1'b0}};
                    end else begin
                        r_state <= HUNT;
                    end
                end
                LOCKED: begin
                    if (w_match) begin
                        r_ref <= q_in;
                        if (r_ref[WIDTH-1]) begin
                            r_wrap      <= 1'b1;
                            r_rev_count <= r_rev_count + {{(REV_CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        r_err    <= 1'b1;
                        r_locked <= 1'b0;
                        if (r_err_count != ERR_SAT) begin
                            r_err_count <= r_err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
                        end
                        if (w_is_onehot) begin
                            r_ref     <= q_in;
                            r_acq_cnt <= {ACQ_W{1'b0}};
                            r_state   <= ACQ;
                        end else begin
                            r_state <= HUNT;
                        end
                    end
                end
                default: begin
                    r_state  <= HUNT;
                    r_locked <= 1'b0;
                end
            endcase
        end else begin
            r_err  <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

    assign idx       = r_idx;
    assign idx_valid = r_idx_valid;
    assign locked    = r_locked;
    assign err       = r_err;
    assign err_count = r_err_count;
    assign wrap      = r_wrap;
    assign rev_count = r_rev_count;

endmodule

// File: tb/tb_ring_counter_checker.sv
// Randomized and directed bench for ring_counter_checker against a
// position-based reference model.
module tb_ring_counter_checker;

    localparam int W  = 4;
    localparam int LC = 2;
    localparam int IW = $clog2(W);

    logic          clk;
    logic          reset;
    logic [W-1:0]  q_in;
    logic          in_valid;
    logic [IW-1:0] idx;
    logic          idx_valid;
    logic          locked;
    logic          err;
    logic [7:0]    err_count;
    logic          wrap;
    logic [15:0]   rev_count;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0=hunt 1=acquire 2=locked, position of last accepted bit
    int m_mode, m_pos, m_run, m_idx, m_idxv, m_err, m_wrap, m_errc, m_revc;

    ring_counter_checker #(.WIDTH(W), .LOCK_CYCLES(LC)) dut (
        .clk       (clk),
        .reset     (reset),
        .q_in      (q_in),
        .in_valid  (in_valid),
        .idx       (idx),
        .idx_valid (idx_valid),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
        .wrap      (wrap),
        .rev_count (rev_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] word_at(input int p);
        logic [W-1:0] w;
        w = '0;
        w[p] = 1'b1;
        return w;
    endfunction

    function automatic int pos_of(input logic [W-1:0] w);
        int p;
        p = 0;
        for (int i = 0; i < W; i++) if (w[i]) p = i;
        return p;
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [W-1:0] w);
        bit oh;
        bit nxt;
        oh = ($countones(w) == 1);
        if (r) begin
            m_mode = 0; m_pos = 0; m_run = 0; m_idx = 0; m_idxv = 0;
            m_err = 0; m_wrap = 0; m_errc = 0; m_revc = 0;
        end else if (!v) begin
            m_err = 0; m_wrap = 0;
        end else begin
            m_err = 0; m_wrap = 0;
            m_idxv = oh;
            if (oh) m_idx = pos_of(w);
            nxt = oh && (m_mode != 0) && (pos_of(w) == (m_pos + 1) % W);
            if (m_mode == 0) begin
                if (oh) begin m_pos = pos_of(w); m_run = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (nxt) begin
                    m_pos = pos_of(w); m_run++;
                    if (m_run == LC) m_mode = 2;
                end else if (oh) begin
                    m_pos = pos_of(w); m_run = 0;
                end else begin
                    m_mode = 0;
                end
            end else begin
                if (nxt) begin
                    if (m_pos == W - 1) begin
                        m_wrap = 1;
                        m_revc = (m_revc + 1) % 65536;
                    end
                    m_pos = pos_of(w);
                end else begin
                    m_err = 1;
                    if (m_errc < 255) m_errc++;
                    if (oh) begin m_pos = pos_of(w); m_run = 0; m_mode = 1; end
                    else m_mode = 0;
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [W-1:0] w);
        reset = r; in_valid = v; q_in = w;
        @(posedge clk);
        model_step(r, v, w);
        #1;
        check_val("idx",       32'(idx),       32'(m_idx));
        check_val("idx_valid", 32'(idx_valid), 32'(m_idxv));
        check_val("locked",    32'(locked),    32'(m_mode == 2));
        check_val("err",       32'(err),       32'(m_err));
        check_val("err_count", 32'(err_count), 32'(m_errc));
        check_val("wrap",      32'(wrap),      32'(m_wrap));
        check_val("rev_count", 32'(rev_count), 32'(m_revc));
    endtask

    task automatic feed_next();
        cycle(1'b0, 1'b1, word_at((m_pos + 1) % W));
    endtask

    initial begin
        logic [W-1:0] rw;
        int sel;
        reset = 1'b1; in_valid = 1'b0; q_in = '0;
        m_mode = 0; m_pos = 0; m_run = 0; m_idx = 0; m_idxv = 0;
        m_err = 0; m_wrap = 0; m_errc = 0; m_revc = 0;

        // Reset state
        cycle(1'b1, 1'b0, 4'b0000);
        check_val("rst_locked", 32'(locked), 32'd0);
        check_val("rst_rev",    32'(rev_count), 32'd0);

        // Lock and first wrap
        cycle(1'b0, 1'b1, 4'b0001);
        cycle(1'b0, 1'b1, 4'b0010);
        cycle(1'b0, 1'b1, 4'b0100);
        check_val("lock_after3", 32'(locked), 32'd1);
        cycle(1'b0, 1'b1, 4'b1000);
        cycle(1'b0, 1'b1, 4'b0001);
        check_val("first_wrap", 32'(wrap), 32'd1);
        check_val("first_rev",  32'(rev_count), 32'd1);
        check_val("idx_wrap0",  32'(idx), 32'd0);

        // Sequence break while locked, then relock
        cycle(1'b0, 1'b1, 4'b0010);
        cycle(1'b0, 1'b1, 4'b1000);
        check_val("break_err",  32'(err), 32'd1);
        check_val("break_cnt",  32'(err_count), 32'd1);
        check_val("break_lock", 32'(locked), 32'd0);
        cycle(1'b0, 1'b1, 4'b0001);
        cycle(1'b0, 1'b1, 4'b0010);
        check_val("relock", 32'(locked), 32'd1);

        // Stall while locked
        cycle(1'b0, 1'b1, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, word_at($urandom_range(W - 1, 0)));
            check_val("stall_idx", 32'(idx), 32'd2);
        end
        cycle(1'b0, 1'b1, 4'b1000);
        check_val("stall_after", 32'(idx), 32'd3);

        // Invalid words in hunt
        cycle(1'b1, 1'b1, 4'b0001);
        cycle(1'b0, 1'b1, 4'b0000);
        cycle(1'b0, 1'b1, 4'b0110);
        check_val("hunt_idxv", 32'(idx_valid), 32'd0);
        check_val("hunt_errc", 32'(err_count), 32'd0);

        // Saturation: lock then break, 260 times
        cycle(1'b0, 1'b1, 4'b0001);
        for (int k = 0; k < 260; k++) begin
            for (int j = 0; j < LC; j++) feed_next();
            cycle(1'b0, 1'b1, word_at((m_pos + 2) % W));
            check_val("sat_err_pulse", 32'(err), 32'd1);
        end
        check_val("sat_value", 32'(err_count), 32'd255);

        // Reset while locked with five revolutions
        cycle(1'b1, 1'b0, 4'b0000);
        cycle(1'b0, 1'b1, 4'b0001);
        while (m_revc < 5) feed_next();
        check_val("rev5", 32'(rev_count), 32'd5);
        cycle(1'b1, 1'b1, word_at((m_pos + 1) % W));
        check_val("rst_mid_lock", 32'(locked), 32'd0);
        cycle(1'b0, 1'b1, 4'b0001);
        cycle(1'b0, 1'b1, 4'b0010);
        check_val("relock_partial", 32'(locked), 32'd0);
        cycle(1'b0, 1'b1, 4'b0100);
        check_val("relock_full", 32'(locked), 32'd1);

        // Randomized mix against the model
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(99, 0);
            if (sel < 55)      rw = word_at((m_pos + 1) % W);
            else if (sel < 75) rw = word_at($urandom_range(W - 1, 0));
            else               rw = W'($urandom);
            cycle(($urandom_range(199, 0) == 0), ($urandom_range(9, 0) != 0), rw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ring_counter_checker.md
# ring_counter_checker

Receive-side monitor for a one-hot ring counter bus. Samples a WIDTH-bit ring word, checks it is one-hot and advances by exactly one left rotation per valid sample, and locks onto the sequence after a run of correct steps. Reports the binary position, lock status, error pulses and saturating error count, and full-revolution count. Sits directly on the `q` output of a `ring_counter`, with `in_valid` tied high for a free-running counter.

## Interface
- `WIDTH`, 4: ring width in bits; at least 2.
- `LOCK_CYCLES`, 2: consecutive correct transitions needed to declare lock; at least 1.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high; overrides all other inputs.
- `q_in` input WIDTH: ring word under test.
- `in_valid` input 1: `q_in` is sampled on a rising edge only when this is high.
- `idx` output $clog2(WIDTH): binary position of the set bit in the last one-hot sample.
- `idx_valid` output 1: last sample was one-hot.
- `locked` output 1: state is LOCKED.
- `err` output 1: one-cycle pulse on a sequence break while LOCKED.
- `err_count` output 8: saturating error count; holds at 255.
- `wrap` output 1: one-cycle pulse when a LOCKED transition goes from bit WIDTH-1 to bit 0.
- `rev_count` output 16: number of `wrap` events; wraps modulo 2^16.

## Operation
- **One-hot check:** exactly one bit set. `0` and multi-bit words are invalid.
- **Expected next word:** `{ref[WIDTH-2:0], ref[WIDTH-1]}`, where `ref` is the last accepted sample.
- **Samples:** every action below happens only on edges with `in_valid` high. With `in_valid` low, all state, `ref`, counters, `idx` and `idx_valid` hold, and `err` and `wrap` stay 0.
- **FSM states:** HUNT, ACQ, LOCKED. Reset state is HUNT.
- **HUNT:**
  - Invalid sample: stay in HUNT.
  - One-hot sample: `ref` ← sample, `acq_cnt` ← 0, go to ACQ.
  - Never raises `err`.
- **ACQ:**
  - Sample equals expected: `ref` ← sample, `acq_cnt`+1. When `acq_cnt`+1 equals LOCK_CYCLES, go to LOCKED.
  - One-hot but not expected: `ref` ← sample, `acq_cnt` ← 0, stay in ACQ.
  - Invalid sample: go to HUNT.
  - No `err`.
- **LOCKED:**
  - Sample equals expected: `ref` ← sample. If `ref` was bit WIDTH-1, pulse `wrap` and increment `rev_count`.
  - Any other sample: pulse `err` and increment `err_count` (saturating at 255).
    - Then, if the sample is one-hot: `ref` ← sample, `acq_cnt` ← 0, go to ACQ.
    - Otherwise go to HUNT.
- **Index outputs:** `idx` and `idx_valid` update on every valid sample, in any state.
  - `idx_valid` = one-hot check result.
  - `idx` = encoded position when one-hot; otherwise `idx` holds its previous value.
- **Counters:** `err_count` and `rev_count` clear only on reset. Lock loss does not clear them.

## Timing
- All outputs are registered and appear on the edge after the sampling edge, i.e. one cycle of latency from sample to outputs.
- `locked` rises on the same edge that takes the LOCK_CYCLES-th correct transition.
- `err` and `wrap` are high for exactly one cycle per event. They cannot both be high in the same cycle.
- **Reset values:** `idx`=0, `idx_valid`=0, `locked`=0, `err`=0, `err_count`=0, `wrap`=0, `rev_count`=0, state=HUNT, `ref`=0, `acq_cnt`=0.
- Reset mid-operation: applied on the edge it is sampled high, regardless of `in_valid`; no partial event is counted.
- The first sample after reset is always handled as HUNT.

## Structure
- Package `ring_pkg` holds:
  - the state enum (HUNT/ACQ/LOCKED);
  - `ERR_CNT_W`=8 and `REV_CNT_W`=16;
  - the `ERR_SAT` constant.
- Sub-module `onehot_to_bin` is purely combinational, parameterised by WIDTH.
  - Outputs the binary index and a `is_onehot` flag.
  - It is shared with future ring/Johnson decoders.
- The top level holds the FSM, `ref`, `acq_cnt`, both counters and the output registers.

## Test plan
1. **Lock and first wrap.** WIDTH=4. Reset for 1 cycle, then feed 0001,0010,0100,1000,0001 with `in_valid`=1.
   - `locked`=1 after the third sample.
   - `idx` follows 0,1,2,3,0.
   - `wrap` pulses once and `rev_count`=1 after the fifth sample.
2. **Sequence break.** While locked after 0010, inject 1000.
   - `err` pulses and `err_count`=1; state is ACQ and `locked`=0.
   - Then 0001,0010 → `locked`=1 again.
3. **Invalid words in HUNT.** Feed 0000 then 0110.
   - `idx_valid`=0, state stays HUNT, `err`=0, `err_count`=0.
4. **Stall.** Locked at 0100, then `in_valid`=0 for 3 cycles, then 1000 with `in_valid`=1.
   - No `err`; `locked` stays 1.
   - `idx`=2 during the stall, then 3.
5. **Saturation.** Alternate lock and break 260 times.
   - `err_count` stops at 255; `err` still pulses on each break.
6. **Reset while locked.** Assert `reset` while locked with `rev_count`=5 and `in_valid`=1.
   - Next cycle all outputs are 0 and state is HUNT.
   - Relock then needs the full LOCK_CYCLES again.
